ram_writer: RTL and testbench

RAM_WRITER -- requirements
Module: ram_writer

---
 rtl/ram_writer.sv | 195 +++++++++++++++++++
 tb/tb_ram_writer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_writer.sv
// ram_writer: streams DEPTH source words into a single-port RAM, one write per
// valid/ready handshake, with registered RAM-side outputs (1-cycle latency).
// Optional readback checksum verification is enabled by the macro
// RAM_WR_READBACK_EN; without it there is no VERIFY state and err is 0.
module ram_writer #(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 12
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

`ifdef RAM_WR_READBACK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, VERIFY = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                ena_q, ena_d;
    logic                wea_q, wea_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   dina_q, dina_d;

`ifdef RAM_WR_READBACK_EN
    logic [15:0]         sum_wr_q, sum_wr_d;
    logic [15:0]         sum_rd_q, sum_rd_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic                issue_done_q, issue_done_d;
    logic                rd_pend_q, rd_pend_d;
    logic                err_q, err_d;
`else
    logic                unused_douta;
    assign unused_douta = ^douta;
`endif

    // State and RAM-side output registers, cleared asynchronously.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            ena_q        <= 1'b0;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            dina_q       <= '0;
`ifdef RAM_WR_READBACK_EN
            sum_wr_q     <= '0;
            sum_rd_q     <= '0;
            rd_cnt_q     <= '0;
            issue_done_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ena_q        <= ena_d;
            wea_q        <= wea_d;
            addra_q      <= addra_d;
            dina_q       <= dina_d;
`ifdef RAM_WR_READBACK_EN
            sum_wr_q     <= sum_wr_d;
            sum_rd_q     <= sum_rd_d;
            rd_cnt_q     <= rd_cnt_d;
            issue_done_q <= issue_done_d;
            rd_pend_q    <= rd_pend_d;
            err_q        <= err_d;
`endif
        end
    end

    // Next-state logic; abort outranks a simultaneous handshake.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        ena_d        = 1'b0;
        wea_d        = 1'b0;
        addra_d      = addra_q;
        dina_d       = dina_q;
`ifdef RAM_WR_READBACK_EN
        sum_wr_d     = sum_wr_q;
        sum_rd_d     = sum_rd_q;
        rd_cnt_d     = rd_cnt_q;
        issue_done_d = issue_done_q;
        rd_pend_d    = 1'b0;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d      = FILL;
                    ptr_d        = '0;
`ifdef RAM_WR_READBACK_EN
                    sum_wr_d     = '0;
                    sum_rd_d     = '0;
                    rd_cnt_d     = '0;
                    issue_done_d = 1'b0;
                    err_d        = 1'b0;
`endif
                end
            end
            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else if (s_valid) begin
                    ena_d   = 1'b1;
                    wea_d   = 1'b1;
                    addra_d = ptr_q;
                    dina_d  = s_data;
`ifdef RAM_WR_READBACK_EN
                    sum_wr_d = sum_wr_q + 16'(s_data);
`endif
                    if (ptr_q == LAST) begin
                        ptr_d = '0;
`ifdef RAM_WR_READBACK_EN
                        state_d = VERIFY;
`else
                        state_d = DONE;
`endif
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
`ifdef RAM_WR_READBACK_EN
            VERIFY: begin
                if (abort) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    // Issue one read address per cycle until all are out.
                    if (!issue_done_q) begin
                        ena_d   = 1'b1;
                        addra_d = ptr_q;
                        if (ptr_q == LAST) begin
                            ptr_d        = '0;
                            issue_done_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                    // A read presented this cycle returns data next cycle.
                    rd_pend_d = ena_q && !wea_q;
                    if (rd_pend_q) begin
                        sum_rd_d = sum_rd_q + 16'(douta);
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        if (rd_cnt_q == LAST) begin
                            err_d   = (sum_rd_d != sum_wr_q);
                            state_d = DONE;
                        end
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_ready = (state_q == FILL);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign ena     = ena_q;
    assign wea     = wea_q;
    assign addra   = addra_q;
    assign dina    = dina_q;
`ifdef RAM_WR_READBACK_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_ram_writer.sv
// Directed testbench for ram_writer at DEPTH=16; readback scenarios are
// included when RAM_WR_READBACK_EN is defined.
module tb_ram_writer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 12;

    logic          clka    = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic [DW-1:0] douta   = '0;
    logic          s_ready, ena, wea, busy, done, err;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit corrupt  = 1'b0;

    int            hs_cyc_q[$];
    int            wr_cyc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic [AW-1:0] rd_addr_q[$];
    logic [DW-1:0] mem [DEPTH];

    ram_writer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clka(clka), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    // RAM model: one-cycle read latency, optional corruption of word 3.
    always @(posedge clka) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            douta <= mem[addra] ^ ((corrupt && addra == 4'd3 && !wea) ? 12'h001 : 12'h000);
        end
    end

    // Transaction recorder sampled on the falling edge.
    always @(negedge clka) begin
        if (rst_n) begin
            if (s_valid && s_ready && !abort) hs_cyc_q.push_back(cyc);
            if (ena && wea) begin
                wr_addr_q.push_back(addra);
                wr_data_q.push_back(dina);
                wr_cyc_q.push_back(cyc);
                $display("cyc %0d: write addr=%0d data=%h", cyc, addra, dina);
            end
            if (ena && !wea) rd_addr_q.push_back(addra);
            if (done) begin
                done_cnt++;
                $display("cyc %0d: done err=%b", cyc, err);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic clear();
        hs_cyc_q.delete();
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        done_cnt = 0;
    endtask

    // Drives s_valid/s_data until n handshakes have been presented (bounded).
    task automatic fill_words(input int n, input logic [DW-1:0] base, input bit toggle);
        int k = 0;
        int g = 0;
        bit v = 1'b1;
        while (k < n && g < 200) begin
            s_valid = v;
            s_data  = base + DW'(k);
            if (v && s_ready) k++;
            step();
            g++;
            if (toggle) v = !v;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ena, wea, addra, dina, s_ready, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all 0",
                     {ena, wea, addra, dina, s_ready, busy, done, err});
        end
        @(negedge clka) rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b s_ready=%b want 0 0", busy, s_ready);
        end
    endtask

    // Runs a full frame and checks address, data and latency of every write.
    task automatic test_frame(input logic [DW-1:0] base, input bit toggle, input string nm);
        clear();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_enter: s_ready=%b busy=%b want 1 1", nm, s_ready, busy);
        end
        fill_words(DEPTH, base, toggle);
        n_checks++;
        if (s_ready !== 1'b0 || ena !== 1'b1 || addra !== 4'd15) begin
            n_fail++;
            $display("FAIL %s_last: s_ready=%b ena=%b addra=%0d want 0 1 15", nm, s_ready, ena, addra);
        end
        repeat (30) step();
        n_checks++;
        if (wr_addr_q.size() != DEPTH || hs_cyc_q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL %s_count: writes=%0d handshakes=%0d want 16 16", nm, wr_addr_q.size(), hs_cyc_q.size());
        end
        for (int i = 0; i < DEPTH && i < wr_addr_q.size() && i < hs_cyc_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== base + DW'(i) || wr_cyc_q[i] != hs_cyc_q[i] + 1) begin
                n_fail++;
                $display("FAIL %s_write%0d: addr=%0d data=%h lat=%0d want addr=%0d data=%h lat=1",
                         nm, i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - hs_cyc_q[i], i, base + DW'(i));
            end
        end
        n_checks++;
        if (done_cnt != 1 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done_cnt=%0d busy=%b err=%b want 1 0 0", nm, done_cnt, busy, err);
        end
    endtask

    task automatic test_abort();
        clear();
        start = 1'b1;
        step();
        start = 1'b0;
        fill_words(5, 12'h300, 1'b0);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 12'hABC;
        step();
        abort   = 1'b0;
        s_valid = 1'b0;
        n_checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || ena !== 1'b0 || wea !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop: s_ready=%b busy=%b ena=%b wea=%b want 0 0 0 0", s_ready, busy, ena, wea);
        end
        repeat (5) step();
        n_checks++;
        if (wr_addr_q.size() != 5 || wr_addr_q[4] !== 4'd4 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_writes: writes=%0d done_cnt=%0d want 5 0", wr_addr_q.size(), done_cnt);
        end
        test_frame(12'h400, 1'b0, "abort_restart");
    endtask

    task automatic test_reset_mid();
        clear();
        start = 1'b1;
        step();
        start = 1'b0;
        fill_words(9, 12'h500, 1'b0);
        s_valid = 1'b1;
        s_data  = 12'h509;
        n_checks++;
        if (ena !== 1'b1 || addra !== 4'd8 || dina !== 12'h508) begin
            n_fail++;
            $display("FAIL rstmid_pre: ena=%b addra=%0d dina=%h want 1 8 508", ena, addra, dina);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ena, wea, addra, dina, s_ready, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b want all 0", {ena, wea, addra, dina, s_ready, busy, done, err});
        end
        step();
        @(negedge clka) rst_n = 1'b1;
        s_valid = 1'b0;
        repeat (20) step();
        n_checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: done_cnt=%0d busy=%b want 0 0", done_cnt, busy);
        end
        test_frame(12'h600, 1'b0, "rstmid_restart");
    endtask

    task automatic test_back_to_back();
        int g = 0;
        int bad = 0;
        clear();
        start = 1'b1;
        step();
        fill_words(DEPTH, 12'h700, 1'b0);
        while (!done && g < 60) begin
            step();
            g++;
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b busy=%b want 1 1", done, busy);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done);
        end
        step();
        start = 1'b0;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_refill: s_ready=%b want 1", s_ready);
        end
        for (int i = 0; i < wr_addr_q.size(); i++) if (wr_addr_q[i] !== AW'(i)) bad++;
        n_checks++;
        if (bad != 0 || wr_addr_q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL b2b_addr: writes=%0d misplaced=%0d want 16 0", wr_addr_q.size(), bad);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_abort: busy=%b want 0", busy);
        end
    endtask

    task automatic test_idle_abort();
        start = 1'b1;
        abort = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_abort_start: busy=%b s_ready=%b want 0 0", busy, s_ready);
        end
        start = 1'b0;
        step();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || ena !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_abort: busy=%b ena=%b want 0 0", busy, ena);
        end
    endtask

`ifdef RAM_WR_READBACK_EN
    task automatic test_readback(input bit c);
        int g = 0;
        int bad = 0;
        clear();
        corrupt = c;
        start = 1'b1;
        step();
        start = 1'b0;
        fill_words(DEPTH, 12'h100, 1'b0);
        while (!done && g < 60) begin
            step();
            g++;
        end
        n_checks++;
        if (done !== 1'b1 || err !== c) begin
            n_fail++;
            $display("FAIL rb%0d_done: done=%b err=%b want 1 %b", c, done, err, c);
        end
        for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] !== AW'(i)) bad++;
        n_checks++;
        if (rd_addr_q.size() != DEPTH || bad != 0) begin
            n_fail++;
            $display("FAIL rb%0d_reads: reads=%0d misplaced=%0d want 16 0", c, rd_addr_q.size(), bad);
        end
        repeat (5) step();
        n_checks++;
        if (err !== c || busy !== 1'b0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL rb%0d_hold: err=%b busy=%b done_cnt=%0d want %b 0 1", c, err, busy, done_cnt, c);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL rb%0d_clear: err=%b want 0", c, err);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        corrupt = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame(12'h100, 1'b0, "fill");
        test_frame(12'h200, 1'b1, "toggle");
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_idle_abort();
`ifdef RAM_WR_READBACK_EN
        test_readback(1'b0);
        test_readback(1'b1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
